operand_regs: RTL and testbench

Operand register bank on the shared 8-bit bus. It captures bus values into registers A and B and feeds them continuously to the adder/subtractor ALU as `reg_a`/`reg_b`. It can also drive either register back onto the bus through a tri-state buffer. Per-register valid bits, an operands-ready handshake and sticky error flags let the control sequencer know when both operands are loaded, consumed, overwritten or misused.

---
 rtl/operand_regs.sv | 96 +++++++++
 tb/tb_operand_regs.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/operand_regs.sv
// Operand register bank: captures bus values into A/B, feeds the ALU, and can
// drive either register back onto the shared tri-state bus.

module operand_regs_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             consume,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             overrun_set
);
  // A load outranks consume, so a consume/load overlap keeps the lane valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      valid <= 1'b0;
    end else begin
      if (load)         q <= d;
      if (load)         valid <= 1'b1;
      else if (consume) valid <= 1'b0;
    end
  end

  assign overrun_set = load & valid & ~consume;
endmodule

module operand_regs #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] bus,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             drive_a,
  input  logic             drive_b,
  input  logic             consume,
  input  logic             clear_err,
  output logic [WIDTH-1:0] reg_a,
  output logic [WIDTH-1:0] reg_b,
  output logic             operands_ready,
  output logic             conflict_err,
  output logic             overrun_err
);
  localparam int NUM_REGS = 2;

  logic [NUM_REGS-1:0]            load;
  logic [NUM_REGS-1:0]            vld;
  logic [NUM_REGS-1:0]            ovr_set;
  logic [NUM_REGS-1:0][WIDTH-1:0] q;
  logic                           drv_one;
  logic                           drv_conflict;

  assign load = {load_b, load_a};

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_lane
      operand_regs_lane #(.WIDTH(WIDTH)) u_lane (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load[g]),
        .consume     (consume),
        .d           (bus),
        .q           (q[g]),
        .valid       (vld[g]),
        .overrun_set (ovr_set[g])
      );
    end
  endgenerate

  // Exactly one drive request wins the bus; a double request floats it, and
  // reset floats it regardless of the drive inputs.
  assign drv_one      = drive_a ^ drive_b;
  assign drv_conflict = drive_a & drive_b;
  assign bus          = (rst_n && drv_one) ? (drive_a ? q[0] : q[1]) : {WIDTH{1'bz}};

  assign reg_a          = q[0];
  assign reg_b          = q[1];
  assign operands_ready = &vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_err <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      if (drv_conflict)   conflict_err <= 1'b1;
      else if (clear_err) conflict_err <= 1'b0;
      if (|ovr_set)       overrun_err  <= 1'b1;
      else if (clear_err) overrun_err  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_operand_regs.sv
// Randomised and directed checks of operand_regs against a behavioural model.
module tb_operand_regs;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  tri1  [7:0] bus;
  logic       load_a = 0, load_b = 0, drive_a = 0, drive_b = 0;
  logic       consume = 0, clear_err = 0;
  logic [7:0] reg_a, reg_b;
  logic       operands_ready, conflict_err, overrun_err;
  logic       tb_en = 0;
  logic [7:0] tb_val = '0;

  int n_chk = 0, n_fail = 0;

  // Reference state
  logic [7:0] ma, mb, bus_s, mbus;
  logic       va, vb, ce, oe;

  assign bus = tb_en ? tb_val : 8'bz;

  always #5 clk = ~clk;

  operand_regs #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .load_a(load_a), .load_b(load_b), .drive_a(drive_a), .drive_b(drive_b),
    .consume(consume), .clear_err(clear_err),
    .reg_a(reg_a), .reg_b(reg_b), .operands_ready(operands_ready),
    .conflict_err(conflict_err), .overrun_err(overrun_err)
  );

  function automatic logic [7:0] model_bus();
    if (!rst_n)                 return 8'hFF;
    if (drive_a && !drive_b)    return ma;
    if (drive_b && !drive_a)    return mb;
    if (tb_en)                  return tb_val;
    return 8'hFF;               // pulled-up, nobody driving
  endfunction

  task automatic model_reset();
    ma = 0; mb = 0; va = 0; vb = 0; ce = 0; oe = 0;
  endtask

  task automatic set_in(input logic la, lb, da, db, cons, clr, en, input logic [7:0] v);
    load_a = la; load_b = lb; drive_a = da; drive_b = db;
    consume = cons; clear_err = clr; tb_en = en; tb_val = v;
  endtask

  // Sample the bus mid-cycle, advance the model with pre-edge inputs, then
  // step past the rising edge.
  task automatic tick();
    logic [7:0] bv;
    @(negedge clk);
    bus_s = bus;
    bv = model_bus();
    mbus = bv;
    if ((load_a && va && !consume) || (load_b && vb && !consume)) oe = 1;
    else if (clear_err) oe = 0;
    if (drive_a && drive_b) ce = 1;
    else if (clear_err) ce = 0;
    if (load_a) ma = bv;
    if (load_b) mb = bv;
    va = load_a ? 1'b1 : (consume ? 1'b0 : va);
    vb = load_b ? 1'b1 : (consume ? 1'b0 : vb);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0; model_reset();
    set_in(0, 0, 1, 0, 0, 0, 0, 8'h00);
    #3;
    n_chk++; if (bus !== 8'hFF) begin n_fail++; $display("FAIL reset_bus got %h want FF(pulled Z)", bus); end
    n_chk++; if (reg_a !== 8'h00 || reg_b !== 8'h00) begin n_fail++; $display("FAIL reset_regs got %h/%h want 00/00", reg_a, reg_b); end
    n_chk++; if (operands_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", operands_ready); end
    n_chk++; if (conflict_err !== 1'b0 || overrun_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b%b want 00", conflict_err, overrun_err); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    set_in(0, 0, 0, 0, 0, 0, 0, 8'h00);
    @(posedge clk); #1;
  endtask

  task automatic test_load_ready();
    set_in(1, 0, 0, 0, 0, 0, 1, 8'h3C); tick();
    n_chk++; if (reg_a !== 8'h3C || operands_ready !== 1'b0) begin n_fail++; $display("FAIL load_a got %h rdy %b want 3C rdy 0", reg_a, operands_ready); end
    set_in(0, 1, 0, 0, 0, 0, 1, 8'h05); tick();
    n_chk++; if (reg_b !== 8'h05 || operands_ready !== 1'b1) begin n_fail++; $display("FAIL load_b got %h rdy %b want 05 rdy 1", reg_b, operands_ready); end
    set_in(0, 0, 0, 0, 1, 0, 0, 8'h00); tick();
    n_chk++; if (operands_ready !== 1'b0 || reg_a !== 8'h3C || reg_b !== 8'h05) begin
      n_fail++; $display("FAIL consume got rdy %b %h/%h want 0 3C/05", operands_ready, reg_a, reg_b); end
  endtask

  task automatic test_move_drive();
    set_in(0, 1, 1, 0, 0, 0, 0, 8'h00); tick();
    n_chk++; if (bus_s !== 8'h3C) begin n_fail++; $display("FAIL move_bus got %h want 3C", bus_s); end
    n_chk++; if (reg_b !== 8'h3C || reg_a !== 8'h3C) begin n_fail++; $display("FAIL move_b got %h/%h want 3C/3C", reg_a, reg_b); end
    set_in(0, 0, 0, 1, 0, 0, 0, 8'h00); tick();
    n_chk++; if (bus_s !== 8'h3C) begin n_fail++; $display("FAIL drive_b got %h want 3C", bus_s); end
    set_in(1, 0, 1, 0, 0, 0, 0, 8'h00); tick();
    n_chk++; if (reg_a !== 8'h3C) begin n_fail++; $display("FAIL self_load got %h want 3C", reg_a); end
  endtask

  task automatic test_conflict();
    set_in(0, 0, 1, 1, 0, 0, 0, 8'h00); tick();
    n_chk++; if (bus_s !== 8'hFF) begin n_fail++; $display("FAIL conflict_bus got %h want FF(pulled Z)", bus_s); end
    n_chk++; if (conflict_err !== 1'b1) begin n_fail++; $display("FAIL conflict_set got %b want 1", conflict_err); end
    set_in(0, 0, 0, 0, 0, 1, 0, 8'h00); tick();
    n_chk++; if (conflict_err !== 1'b0) begin n_fail++; $display("FAIL conflict_clr got %b want 0", conflict_err); end
    set_in(0, 0, 1, 1, 0, 1, 0, 8'h00); tick();
    n_chk++; if (conflict_err !== 1'b1) begin n_fail++; $display("FAIL conflict_set_wins got %b want 1", conflict_err); end
    set_in(0, 0, 0, 0, 0, 1, 0, 8'h00); tick();
  endtask

  task automatic test_overrun();
    // Clear valids, then load A twice without consume.
    set_in(0, 0, 0, 0, 1, 0, 0, 8'h00); tick();
    set_in(1, 0, 0, 0, 0, 0, 1, 8'h11); tick();
    n_chk++; if (overrun_err !== 1'b0) begin n_fail++; $display("FAIL overrun_first got %b want 0", overrun_err); end
    set_in(1, 0, 0, 0, 0, 0, 1, 8'h7F); tick();
    n_chk++; if (overrun_err !== 1'b1 || reg_a !== 8'h7F) begin n_fail++; $display("FAIL overrun_set got %b %h want 1 7F", overrun_err, reg_a); end
    set_in(0, 1, 0, 0, 0, 1, 1, 8'h44); tick();
    set_in(1, 0, 0, 0, 1, 0, 1, 8'h22); tick();
    n_chk++; if (overrun_err !== 1'b0 || operands_ready !== 1'b0 || reg_a !== 8'h22) begin
      n_fail++; $display("FAIL load_consume got ovr %b rdy %b %h want 0 0 22", overrun_err, operands_ready, reg_a); end
    set_in(0, 1, 0, 0, 0, 0, 1, 8'h33); tick();
    n_chk++; if (operands_ready !== 1'b1 || overrun_err !== 1'b0) begin
      n_fail++; $display("FAIL a_kept_valid got rdy %b ovr %b want 1 0", operands_ready, overrun_err); end
  endtask

  task automatic test_random();
    logic da, db;
    for (int i = 0; i < 300; i++) begin
      da = ($urandom_range(0, 3) == 0);
      db = ($urandom_range(0, 3) == 0);
      set_in($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, da, db,
             $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
             !(da ^ db) && ($urandom_range(0, 3) != 0), 8'($urandom));
      tick();
      n_chk++; if (bus_s !== mbus) begin n_fail++; $display("FAIL rnd_bus[%0d] got %h want %h", i, bus_s, mbus); end
      n_chk++; if (reg_a !== ma || reg_b !== mb) begin n_fail++; $display("FAIL rnd_regs[%0d] got %h/%h want %h/%h", i, reg_a, reg_b, ma, mb); end
      n_chk++; if (operands_ready !== (va & vb)) begin n_fail++; $display("FAIL rnd_ready[%0d] got %b want %b", i, operands_ready, va & vb); end
      n_chk++; if (conflict_err !== ce || overrun_err !== oe) begin
        n_fail++; $display("FAIL rnd_err[%0d] got %b%b want %b%b", i, conflict_err, overrun_err, ce, oe); end
    end
  endtask

  task automatic test_async_reset();
    set_in(1, 0, 0, 0, 1, 0, 1, 8'hFF); tick();
    set_in(0, 1, 0, 0, 0, 0, 1, 8'h01); tick();
    set_in(0, 0, 0, 1, 0, 0, 0, 8'h00);
    #2;
    rst_n = 0; model_reset();
    #1;
    n_chk++; if (reg_a !== 8'h00 || reg_b !== 8'h00 || operands_ready !== 1'b0) begin
      n_fail++; $display("FAIL async_rst got %h/%h rdy %b want 00/00 0", reg_a, reg_b, operands_ready); end
    n_chk++; if (bus !== 8'hFF) begin n_fail++; $display("FAIL async_rst_bus got %h want FF(pulled Z)", bus); end
    @(negedge clk); rst_n = 1;
    set_in(1, 0, 0, 0, 0, 0, 1, 8'h5A); tick();
    n_chk++; if (operands_ready !== 1'b0 || reg_a !== 8'h5A || reg_b !== 8'h00) begin
      n_fail++; $display("FAIL post_rst got rdy %b %h/%h want 0 5A/00", operands_ready, reg_a, reg_b); end
  endtask

  initial begin
    test_reset();
    test_load_ready();
    test_move_drive();
    test_conflict();
    test_overrun();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
